// File: rtl/program_sequencer.sv
// Fetch/sequence controller: owns the PC, resolves JMP/ATC and NOPs locally and
// offers all other ROM words to the execute unit over a valid/ready handshake.
module program_sequencer #(
    parameter logic [3:0] OP_JMP   = 4'h0,
    parameter logic [3:0] OP_ATC   = 4'h0,
    parameter logic [7:0] RESET_PC = 8'd0,
    parameter bit         SKIP_NOP = 1'b1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        run,
    input  logic        step,
    output logic [7:0]  rom_addr,
    input  logic [34:0] rom_data,
    output logic [34:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        ex_busy,
    input  logic [7:0]  flags,
    output logic [7:0]  flag_clr,
    output logic [7:0]  pc,
    output logic        jump_taken,
    output logic        halted
);

    typedef enum logic [1:0] {ST_HALT, ST_FETCH, ST_ISSUE, ST_DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  pc_reg, pc_next;
    logic [34:0] ir_reg, ir_next;
    logic        ir_valid_reg, ir_valid_next;
    logic        single_reg, single_next;
    logic [2:0]  atc_bit_reg, atc_bit_next;
    logic [7:0]  atc_target_reg, atc_target_next;
    logic        atc_fire;

    logic [3:0]  op;
    logic [2:0]  cond_bit;
    logic [7:0]  target;
    logic        boundary_fetch;

    assign op       = rom_data[34:31];
    assign cond_bit = rom_data[30:28];
    assign target   = rom_data[7:0];

    // Where to go once the current instruction is finished.
    assign boundary_fetch = run & ~single_reg;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg      <= ST_HALT;
            pc_reg         <= RESET_PC;
            ir_reg         <= '0;
            ir_valid_reg   <= 1'b0;
            single_reg     <= 1'b0;
            atc_bit_reg    <= '0;
            atc_target_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ir_reg         <= ir_next;
            ir_valid_reg   <= ir_valid_next;
            single_reg     <= single_next;
            atc_bit_reg    <= atc_bit_next;
            atc_target_reg <= atc_target_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ir_next         = ir_reg;
        ir_valid_next   = ir_valid_reg;
        single_next     = single_reg;
        atc_bit_next    = atc_bit_reg;
        atc_target_next = atc_target_reg;
        jump_taken      = 1'b0;
        atc_fire        = 1'b0;

        case (state_reg)
            ST_HALT: begin
                if (run) begin
                    state_next  = ST_FETCH;
                    single_next = 1'b0;
                end else if (step) begin
                    state_next  = ST_FETCH;
                    single_next = 1'b1;
                end
            end
            ST_FETCH: begin
                // JMP wins over ATC when both opcodes are configured identically.
                if (op == OP_JMP) begin
                    pc_next     = target;
                    jump_taken  = 1'b1;
                    state_next  = boundary_fetch ? ST_FETCH : ST_HALT;
                    single_next = 1'b0;
                end else if (op == OP_ATC) begin
                    atc_bit_next    = cond_bit;
                    atc_target_next = target;
                    state_next      = ST_DRAIN;
                end else if (SKIP_NOP && rom_data == '0) begin
                    pc_next     = pc_reg + 8'd1;
                    state_next  = boundary_fetch ? ST_FETCH : ST_HALT;
                    single_next = 1'b0;
                end else begin
                    ir_next       = rom_data;
                    ir_valid_next = 1'b1;
                    pc_next       = pc_reg + 8'd1;
                    state_next    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ir_ready) begin
                    ir_valid_next = 1'b0;
                    state_next    = boundary_fetch ? ST_FETCH : ST_HALT;
                    single_next   = 1'b0;
                end
            end
            ST_DRAIN: begin
                // Flags are only trustworthy once execute has gone idle.
                if (!ex_busy) begin
                    if (flags[atc_bit_reg]) begin
                        atc_fire   = 1'b1;
                        jump_taken = 1'b1;
                        pc_next    = atc_target_reg;
                    end else begin
                        pc_next = pc_reg + 8'd1;
                    end
                    state_next  = boundary_fetch ? ST_FETCH : ST_HALT;
                    single_next = 1'b0;
                end
            end
            default: state_next = ST_HALT;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_flag_clr
            assign flag_clr[gi] = atc_fire && (atc_bit_reg == 3'(gi));
        end
    endgenerate

    assign rom_addr = pc_reg;
    assign pc       = pc_reg;
    assign ir       = ir_reg;
    assign ir_valid = ir_valid_reg;
    assign halted   = (state_reg == ST_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: table-driven single steps plus
// hand-written multi-cycle sequences, with an issue scoreboard.
module tb_program_sequencer;

    localparam logic [3:0] OP_J = 4'hA;
    localparam logic [3:0] OP_A = 4'hB;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  rom_addr;
    logic [34:0] rom_data;
    logic [34:0] ir;
    logic        ir_valid;
    logic        ir_ready = 1'b1;
    logic        ex_busy = 1'b0;
    logic [7:0]  flags = 8'h00;
    logic [7:0]  flag_clr;
    logic [7:0]  pc;
    logic        jump_taken;
    logic        halted;

    logic [34:0] rom [256];
    logic [34:0] sb [$];

    int errors = 0;
    int checks = 0;
    int issued_count = 0;
    int jt_count = 0;
    logic [7:0] clr_seen = 8'h00;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    program_sequencer #(
        .OP_JMP(OP_J), .OP_ATC(OP_A), .RESET_PC(8'd0), .SKIP_NOP(1'b1)
    ) dut (
        .clk(clk), .nreset(nreset), .run(run), .step(step),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .ex_busy(ex_busy), .flags(flags), .flag_clr(flag_clr),
        .pc(pc), .jump_taken(jump_taken), .halted(halted)
    );

    function automatic logic [34:0] mk(input logic [3:0] op, input logic [2:0] cb, input logic [7:0] tgt);
        return {op, cb, 20'h0, tgt};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard / event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (nreset) begin
            if (ir_valid && ir_ready) begin
                issued_count++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got %0h expected none", ir);
                end else begin
                    logic [34:0] e;
                    e = sb.pop_front();
                    if (ir !== e) begin
                        errors++;
                        $display("FAIL issue_word: got %0h expected %0h", ir, e);
                    end
                end
            end
            if (jump_taken) jt_count++;
            clr_seen |= flag_clr;
        end
    end

    task automatic do_reset;
        @(posedge clk); #1;
        run = 1'b0; step = 1'b0; nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        sb.delete();
        jt_count = 0;
        clr_seen = 8'h00;
    endtask

    task automatic pulse_step;
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
    endtask

    task automatic wait_halted(input string name);
        int n = 0;
        while (!halted && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(halted), 64'd1);
    endtask

    task automatic goto_addr(input logic [7:0] a);
        rom[0] = mk(OP_J, 3'd0, a);
        do_reset();
        pulse_step();
        wait_halted("goto_halt");
        @(negedge clk);
        jt_count = 0;
        clr_seen = 8'h00;
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [34:0] word;
        logic [7:0]  flg;
        int          exp_issue;
        logic [7:0]  exp_pc;
        int          exp_jt;
        logic [7:0]  exp_clr;
    } vec_t;

    vec_t vecs [8];
    logic [34:0] mov_a, mov_b;

    initial begin
        int base;
        int n;
        mov_a = {4'h1, 3'h2, 20'hABCDE, 8'h33};
        mov_b = {4'h3, 3'h5, 20'h12345, 8'hC4};
        for (int i = 0; i < 256; i++) rom[i] = '0;

        vecs[0] = '{8'd5,   mov_a,                   8'h00, 1, 8'd6,    0, 8'h00};
        vecs[1] = '{8'd10,  mk(OP_J, 3'd7, 8'h40),   8'h00, 0, 8'h40,   1, 8'h00};
        vecs[2] = '{8'd20,  mk(OP_A, 3'd3, 8'h77),   8'h08, 0, 8'h77,   1, 8'h08};
        vecs[3] = '{8'd21,  mk(OP_A, 3'd2, 8'd16),   8'h00, 0, 8'd22,   0, 8'h00};
        vecs[4] = '{8'd30,  35'h0,                   8'h00, 0, 8'd31,   0, 8'h00};
        vecs[5] = '{8'd255, mov_b,                   8'h00, 1, 8'd0,    0, 8'h00};
        vecs[6] = '{8'd40,  mk(OP_J, 3'd4, 8'd40),   8'h00, 0, 8'd40,   1, 8'h00};
        vecs[7] = '{8'd50,  mk(OP_A, 3'd7, 8'h02),   8'hFF, 0, 8'h02,   1, 8'h80};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("reset_halted", 64'(halted), 64'd1);
        check("reset_pc", 64'(pc), 64'd0);
        check("reset_ir_valid", 64'(ir_valid), 64'd0);
        check("reset_flag_clr", 64'(flag_clr), 64'd0);
        #1 nreset = 1'b1;

        // Table: one stepped instruction per record
        for (int i = 0; i < 8; i++) begin
            rom[vecs[i].addr] = vecs[i].word;
            goto_addr(vecs[i].addr);
            flags = vecs[i].flg;
            ex_busy = 1'b0;
            ir_ready = 1'b1;
            if (vecs[i].exp_issue != 0) sb.push_back(vecs[i].word);
            base = issued_count;
            pulse_step();
            wait_halted("vec_halt");
            @(negedge clk);
            $display("vec %0d addr=%0d pc=%0h jt=%0d clr=%0h issued=%0d", i, vecs[i].addr, pc, jt_count, clr_seen, issued_count - base);
            check("vec_pc", 64'(pc), 64'(vecs[i].exp_pc));
            check("vec_jump_taken", 64'(jt_count), 64'(vecs[i].exp_jt));
            check("vec_flag_clr", 64'(clr_seen), 64'(vecs[i].exp_clr));
            check("vec_issued", 64'(issued_count - base), 64'(vecs[i].exp_issue));
            rom[vecs[i].addr] = '0;
        end

        // Reset in the middle of an unaccepted issue
        rom[5] = mov_a;
        goto_addr(8'd5);
        ir_ready = 1'b0;
        sb.push_back(mov_a);
        pulse_step();
        n = 0;
        while (!ir_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("mid_issue_valid", 64'(ir_valid), 64'd1);
        @(posedge clk); #3 nreset = 1'b0;
        #1;
        check("async_rst_ir_valid", 64'(ir_valid), 64'd0);
        check("async_rst_pc", 64'(pc), 64'd0);
        check("async_rst_halted", 64'(halted), 64'd1);
        check("async_rst_ir", 64'(ir), 64'd0);
        $display("async reset mid-issue: ir_valid=%0b pc=%0h halted=%0b", ir_valid, pc, halted);
        sb.delete();
        #3 nreset = 1'b1;
        ir_ready = 1'b1;

        // Free-run loop: MOV, MOV, JMP 0
        rom[5] = '0;
        do_reset();
        rom[0] = mov_a;
        rom[1] = mov_b;
        rom[2] = mk(OP_J, 3'd5, 8'd0);
        for (int k = 0; k < 3; k++) begin sb.push_back(mov_a); sb.push_back(mov_b); end
        base = issued_count;
        @(posedge clk); #1 run = 1'b1;
        n = 0;
        while ((issued_count - base) < 6 && n < 100) begin @(posedge clk); #1; n++; end
        run = 1'b0;
        wait_halted("run_halt");
        @(negedge clk);
        $display("run loop: issued=%0d jumps=%0d pc=%0h", issued_count - base, jt_count, pc);
        check("run_issued", 64'(issued_count - base), 64'd6);
        check("run_jumps", 64'(jt_count), 64'd3);
        check("run_pc", 64'(pc), 64'd0);
        check("run_sb_empty", 64'(sb.size()), 64'd0);

        // ATC waits for ex_busy before resolving
        rom[1] = '0;
        rom[2] = '0;
        rom[20] = mk(OP_A, 3'd2, 8'd16);
        goto_addr(8'd20);
        flags = 8'h04;
        ex_busy = 1'b1;
        pulse_step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_no_clr", 64'(flag_clr), 64'd0);
            check("drain_pc", 64'(pc), 64'd20);
        end
        @(posedge clk); #1 ex_busy = 1'b0;
        wait_halted("drain_halt");
        @(negedge clk);
        $display("atc busy: pc=%0h clr=%0h jt=%0d", pc, clr_seen, jt_count);
        check("drain_pc_final", 64'(pc), 64'd16);
        check("drain_clr", 64'(clr_seen), 64'h04);
        check("drain_jt", 64'(jt_count), 64'd1);
        rom[20] = '0;
        flags = 8'h00;

        // Stepped issue held off by ir_ready
        rom[5] = mov_a;
        goto_addr(8'd5);
        ir_ready = 1'b0;
        sb.push_back(mov_a);
        base = issued_count;
        pulse_step();
        n = 0;
        while (!ir_valid && n < 20) begin @(posedge clk); #1; n++; end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_valid", 64'(ir_valid), 64'd1);
            check("hold_ir", 64'(ir), 64'(mov_a));
        end
        @(posedge clk); #1 ir_ready = 1'b1;
        wait_halted("hold_halt");
        @(negedge clk);
        $display("step hold: pc=%0h issued=%0d", pc, issued_count - base);
        check("hold_pc", 64'(pc), 64'd6);
        check("hold_issued", 64'(issued_count - base), 64'd1);
        rom[5] = '0;

        // NOP at 255 wraps to 0, NOP at 0 skipped
        rom[255] = '0;
        goto_addr(8'd255);
        rom[0] = '0;
        base = issued_count;
        pulse_step();
        wait_halted("wrap_halt1");
        @(negedge clk);
        check("wrap_pc0", 64'(pc), 64'd0);
        pulse_step();
        wait_halted("wrap_halt2");
        @(negedge clk);
        $display("wrap: pc=%0h issued=%0d", pc, issued_count - base);
        check("wrap_pc1", 64'(pc), 64'd1);
        check("wrap_issued", 64'(issued_count - base), 64'd0);
        check("wrap_jt", 64'(jt_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
